// File: rtl/modulo_controlador_jogo_pkg.sv
// modulo_controlador_jogo_pkg: FSM states, status codes and board geometry for the naval-battle sequencer.
package modulo_controlador_jogo_pkg;
  typedef enum logic [2:0] {
    S_SETUP, S_ARMED, S_CHECK, S_WRITE, S_RESULT, S_WIN, S_LOSE
  } state_t;
  localparam logic [3:0] ST_SETUP   = 4'd0;
  localparam logic [3:0] ST_ARMED   = 4'd1;
  localparam logic [3:0] ST_HIT     = 4'd2;
  localparam logic [3:0] ST_MISS    = 4'd3;
  localparam logic [3:0] ST_REPEAT  = 4'd4;
  localparam logic [3:0] ST_INVALID = 4'd5;
  localparam logic [3:0] ST_WIN     = 4'd6;
  localparam logic [3:0] ST_LOSE    = 4'd7;
  localparam logic [2:0] LINES = 3'd7;
  localparam logic [2:0] COLS  = 3'd5;
  function automatic logic in_range(input logic [2:0] l, input logic [2:0] c);
    return (l < LINES) && (c < COLS);
  endfunction
endpackage

// File: rtl/modulo_controlador_jogo_debounce.sv
// modulo_debounce: 2-FF synchroniser, stable-level counter and 1-clk rising-edge event.
module modulo_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic evt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, lvl, take;
  logic [CW-1:0] cnt;
  assign take = (s2 != lvl) && (cnt == CW'(DEB_CYCLES - 1));
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
      evt <= 1'b0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      cnt <= (s2 == lvl || take) ? '0 : cnt + 1'b1;
      if (take) lvl <= s2;
      evt <= take & s2;
    end
endmodule

// File: rtl/modulo_controlador_jogo.sv
// modulo_controlador_jogo: naval-battle game sequencer with debounced buttons and LED/7-seg scan.
// Define SHOT_LIMIT_EN to enable the MAX_SHOTS budget and the LOSE outcome.
module modulo_controlador_jogo
  import modulo_controlador_jogo_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int SCAN_DIV = 2**19,
  parameter int SHIP_CELLS = 9,
`ifdef SHOT_LIMIT_EN
  parameter int MAX_SHOTS = 20,
`endif
  parameter int RESULT_TICKS = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_fire,
  input  logic       btn_new,
  input  logic [1:0] mode,
  input  logic [2:0] coord_line,
  input  logic [2:0] coord_col,
  input  logic       ship_here,
  input  logic       cell_shot,
  output logic       at_we,
  output logic [2:0] at_line,
  output logic [2:0] at_col,
  output logic       matrix_clr,
  output logic [3:0] status,
  output logic [5:0] shots,
  output logic [3:0] hits,
  output logic [2:0] scan_col,
  output logic [1:0] scan_dig,
  output logic       scan_tick
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(RESULT_TICKS + 1);
  state_t state, nxt;
  logic fire_evt, new_evt, valid, win, lose, rdone;
  logic [PW-1:0] pre;
  logic [RW-1:0] rcnt;
  logic [5:0] shots_nx;
  logic [3:0] hits_nx, status_nx;

  modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_fire (.clk(clk), .clr(clr), .btn(btn_fire), .evt(fire_evt));
  modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_new  (.clk(clk), .clr(clr), .btn(btn_new),  .evt(new_evt));

  assign valid     = in_range(at_line, at_col);
  assign shots_nx  = shots == 6'd63 ? shots : shots + 6'd1;
  assign hits_nx   = (ship_here && hits != 4'd15) ? hits + 4'd1 : hits;
  assign win       = hits_nx == 4'(SHIP_CELLS);
`ifdef SHOT_LIMIT_EN
  assign lose      = shots_nx == 6'(MAX_SHOTS);
`else
  assign lose      = 1'b0;
`endif
  assign rdone     = rcnt == RW'(RESULT_TICKS - 1);
  assign scan_tick = pre == PW'(SCAN_DIV - 1);

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state      <= S_SETUP;
      status     <= ST_SETUP;
      shots      <= '0;
      hits       <= '0;
      at_line    <= '0;
      at_col     <= '0;
      matrix_clr <= 1'b0;
      rcnt       <= '0;
      pre        <= '0;
      scan_col   <= '0;
      scan_dig   <= '0;
    end else begin
      state      <= nxt;
      status     <= status_nx;
      matrix_clr <= new_evt;
      rcnt       <= state == S_RESULT ? rcnt + RW'(scan_tick) : '0;
      pre        <= scan_tick ? '0 : pre + 1'b1;
      if (scan_tick) begin
        scan_col <= scan_col == 3'd4 ? 3'd0 : scan_col + 3'd1;
        scan_dig <= scan_dig + 2'd1;
      end
      if (nxt == S_CHECK) begin
        at_line <= coord_line;
        at_col  <= coord_col;
      end
      if (state == S_WRITE) begin
        shots <= shots_nx;
        hits  <= hits_nx;
      end
      if (new_evt) begin
        shots <= '0;
        hits  <= '0;
      end
    end

  always_comb begin
    nxt = state;
    if (new_evt) nxt = S_SETUP;
    else
      case (state)
        S_SETUP:  nxt = mode == 2'b01 ? S_ARMED : S_SETUP;
        S_ARMED:  nxt = mode == 2'b00 ? S_SETUP : fire_evt ? S_CHECK : S_ARMED;
        S_CHECK:  nxt = (!valid || cell_shot) ? S_RESULT : S_WRITE;
        S_WRITE:  nxt = win ? S_WIN : lose ? S_LOSE : S_RESULT;
        S_RESULT: nxt = (scan_tick && rdone) ? S_ARMED : S_RESULT;
        default:  nxt = state;
      endcase
  end

  always_comb begin
    at_we     = state == S_WRITE;
    status_nx = nxt == S_SETUP ? ST_SETUP :
                nxt == S_ARMED ? ST_ARMED :
                nxt == S_WIN   ? ST_WIN :
                nxt == S_LOSE  ? ST_LOSE :
                (nxt == S_RESULT && state == S_CHECK) ? (valid ? ST_REPEAT : ST_INVALID) :
                (nxt == S_RESULT && state == S_WRITE) ? (ship_here ? ST_HIT : ST_MISS) :
                status;
  end
endmodule

// File: tb/tb_modulo_controlador_jogo.sv
// tb_modulo_controlador_jogo: randomized shots checked against a shot-level game model.
module tb_modulo_controlador_jogo;
  localparam int DEB = 4, SDIV = 4, SHIP = 9, MAXS = 3, RT = 2;
`ifdef SHOT_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  logic clk = 0, clr = 0, btn_fire = 0, btn_new = 0, ship_here = 0, cell_shot = 0;
  logic [1:0] mode = 0;
  logic [2:0] coord_line = 0, coord_col = 0;
  logic at_we, matrix_clr, scan_tick;
  logic [2:0] at_line, at_col, scan_col;
  logic [3:0] status, hits;
  logic [5:0] shots;
  logic [1:0] scan_dig;
  int errors = 0, checks = 0;
  int m_shots = 0, m_hits = 0, m_stat = 0;
  bit m_term = 0;

  modulo_controlador_jogo #(
    .DEB_CYCLES(DEB), .SCAN_DIV(SDIV), .SHIP_CELLS(SHIP),
`ifdef SHOT_LIMIT_EN
    .MAX_SHOTS(MAXS),
`endif
    .RESULT_TICKS(RT)
  ) dut (
    .clk(clk), .clr(clr), .btn_fire(btn_fire), .btn_new(btn_new), .mode(mode),
    .coord_line(coord_line), .coord_col(coord_col), .ship_here(ship_here), .cell_shot(cell_shot),
    .at_we(at_we), .at_line(at_line), .at_col(at_col), .matrix_clr(matrix_clr), .status(status),
    .shots(shots), .hits(hits), .scan_col(scan_col), .scan_dig(scan_dig), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_shots"}, shots, m_shots);
    chk({tag, "_hits"}, hits, m_hits);
    chk({tag, "_status"}, status, m_stat);
  endtask

  task automatic fire(input int l, input int c, input bit sh, input bit cs, input bit bounce);
    int we = 0, mc = 0, seen = 15, exp_seen = 15, exp_we = 0, al = 0, ac = 0;
    coord_line = 3'(l); coord_col = 3'(c); ship_here = sh; cell_shot = cs;
    if (!m_term) begin
      if (l > 6 || c > 4) exp_seen = 5;
      else if (cs) exp_seen = 4;
      else begin
        exp_we = 1;
        if (m_shots < 63) m_shots++;
        if (sh && m_hits < 15) m_hits++;
        exp_seen = (m_hits == SHIP) ? 6 : (LIM && m_shots == MAXS) ? 7 : sh ? 2 : 3;
      end
    end
    if (bounce)
      for (int i = 0; i < 10; i++) begin
        btn_fire = ~btn_fire;
        repeat (2) @(negedge clk) begin
          if (at_we) we++;
          if (matrix_clr) mc++;
        end
      end
    btn_fire = 1;
    repeat (14) @(negedge clk) begin
      if (at_we) begin we++; al = at_line; ac = at_col; end
      if (matrix_clr) mc++;
      if (seen == 15 && status != m_stat) seen = status;
    end
    btn_fire = 0;
    repeat (20) @(negedge clk) begin
      if (at_we) we++;
      if (matrix_clr) mc++;
    end
    if (exp_seen >= 6) m_term = 1;
    if (!m_term) m_stat = 1;
    else if (exp_seen != 15) m_stat = exp_seen;
    chk("fire_we", we, exp_we);
    chk("fire_mclr", mc, 0);
    chk("fire_result", seen, exp_seen);
    if (exp_we == 1) begin
      chk("fire_line", al, l);
      chk("fire_col", ac, c);
    end
    check_counters("after_fire");
  endtask

  task automatic new_game();
    int mc = 0;
    mode = 2'b00;
    btn_new = 1;
    repeat (14) @(negedge clk) if (matrix_clr) mc++;
    btn_new = 0;
    repeat (10) @(negedge clk) if (matrix_clr) mc++;
    m_shots = 0; m_hits = 0; m_stat = 0; m_term = 0;
    chk("new_mclr", mc, 1);
    check_counters("new");
    mode = 2'b01;
    repeat (2) @(negedge clk);
    m_stat = 1;
    chk("new_armed", status, 1);
  endtask

  initial begin
    int we, mc, seen;
    #12;
    chk("rst_status", status, 0);
    chk("rst_shots", shots, 0);
    chk("rst_hits", hits, 0);
    chk("rst_we", at_we, 0);
    chk("rst_mclr", matrix_clr, 0);
    chk("rst_col", scan_col, 0);
    chk("rst_tick", scan_tick, 0);
    @(negedge clk) clr = 1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("scan_tick", scan_tick, (k % 4 == 3) ? 1 : 0);
      chk("scan_col", scan_col, (k / 4) % 5);
      chk("scan_dig", scan_dig, (k / 4) % 4);
    end
    chk("setup_status", status, 0);
    mode = 2'b01;
    repeat (2) @(negedge clk);
    m_stat = 1;
    chk("armed_status", status, 1);

    fire(2, 3, 1, 0, 0);
    fire(7, 1, 0, 0, 0);
    fire(2, 3, 1, 1, 0);
    for (int i = 0; i < 10; i++) fire(i % 7, i % 5, 1, 0, 0);
    new_game();
    for (int i = 0; i < 3; i++) fire(i, 4 - i, 0, 0, 0);
    if (m_term) new_game();

    fire(4, 0, 0, 0, 1);
    coord_line = 1; coord_col = 1; cell_shot = 0;
    we = 0; mc = 0;
    btn_fire = 1; btn_new = 1;
    repeat (14) @(negedge clk) begin
      if (at_we) we++;
      if (matrix_clr) mc++;
    end
    btn_fire = 0; btn_new = 0;
    repeat (10) @(negedge clk);
    m_shots = 0; m_hits = 0; m_stat = 1; m_term = 0;
    chk("both_we", we, 0);
    chk("both_mclr", mc, 1);
    check_counters("both");

    for (int n = 0; n < 40; n++) begin
      fire($urandom_range(0, 7), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, 0);
      if (m_term) new_game();
    end

    coord_line = 0; coord_col = 0; ship_here = 0; cell_shot = 0;
    btn_fire = 1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) @(negedge clk) if (at_we) seen = 1;
    chk("midrst_we_seen", seen, 1);
    repeat (3) @(negedge clk);
    #2 clr = 0;
    #1;
    chk("midrst_status", status, 0);
    chk("midrst_shots", shots, 0);
    chk("midrst_hits", hits, 0);
    chk("midrst_we", at_we, 0);
    chk("midrst_mclr", matrix_clr, 0);
    chk("midrst_col", scan_col, 0);
    chk("midrst_dig", scan_dig, 0);
    chk("midrst_tick", scan_tick, 0);
    btn_fire = 0;
    @(negedge clk) clr = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
